// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared widths, FSM states and request layout for the ALU request sequencer
package alu_ctrl_pkg;

  localparam int OPW = 3;
  localparam int DW  = 8;
  localparam int RW  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] op;
  } req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin grant; the pointer register lives in the parent
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant     = 2'b00;
    grant_idx = ptr;
    if (enable) begin
      if (req[ptr]) begin
        grant[ptr] = 1'b1;
        grant_idx  = ptr;
      end else if (req[~ptr]) begin
        grant[~ptr] = 1'b1;
        grant_idx   = ~ptr;
      end
    end
  end

endmodule

// File: rtl/alu_req_sequencer.sv
// rtl/alu_req_sequencer.sv - shares one external ALU between two requesters with a response channel
module alu_req_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*DW-1:0]    req_a,
  input  logic [2*DW-1:0]    req_b,
  input  logic [2*OPW-1:0]   req_op,
  output logic [DW-1:0]      alu_inA,
  output logic [DW-1:0]      alu_inB,
  output logic [OPW-1:0]     alu_opCode,
  input  logic [RW-1:0]      alu_out,
  input  logic               alu_cout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [RW-1:0]      rsp_result,
  output logic               rsp_cout,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  localparam logic [3:0] WAIT_INIT = 4'(ALU_LATENCY - 1);

  state_t     state_q, state_d;
  logic       rr_ptr;
  logic       id_q;
  logic [3:0] wait_cnt;
  logic [1:0] grant;
  logic       grant_idx;
  logic       accept, capture, done;
  req_t       reqs [2];
  req_t       sel;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      reqs[i].a  = req_a[i*DW +: DW];
      reqs[i].b  = req_b[i*DW +: DW];
      reqs[i].op = req_op[i*OPW +: OPW];
    end
  end

  assign sel = reqs[grant_idx];

  rr_arbiter_2 u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .enable    (state_q == IDLE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (|grant) begin
        accept  = 1'b1;
        state_d = EXEC;
      end
      EXEC: if (wait_cnt == 4'd0) begin
        capture = 1'b1;
        state_d = RESP;
      end
      // Returning to IDLE here keeps a new accept out of the handshake cycle.
      RESP: if (rsp_ready) begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr     <= 1'b0;
      id_q       <= 1'b0;
      wait_cnt   <= 4'd0;
      alu_inA    <= '0;
      alu_inB    <= '0;
      alu_opCode <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      op_count   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_inA    <= sel.a;
        alu_inB    <= sel.b;
        alu_opCode <= sel.op;
        id_q       <= grant_idx;
        rr_ptr     <= ~grant_idx;
        wait_cnt   <= WAIT_INIT;
      end
      if (state_q == EXEC && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (capture) begin
        rsp_result <= alu_out;
        rsp_cout   <= alu_cout;
        rsp_id     <= id_q;
        rsp_valid  <= 1'b1;
      end
      if (done) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

endmodule
